// File: rtl/rtclock_if.sv
// AXI4-Lite register bus for the rtclock block.
// The master modport drives requests; the slave modport is taken by rtclock.
interface rtclock_if #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32
);
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic                            S_AXI_AWVALID;
    logic                            S_AXI_AWREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                            S_AXI_WVALID;
    logic                            S_AXI_WREADY;
    logic [1:0]                      S_AXI_BRESP;
    logic                            S_AXI_BVALID;
    logic                            S_AXI_BREADY;
    logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic                            S_AXI_ARVALID;
    logic                            S_AXI_ARREADY;
    logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]                      S_AXI_RRESP;
    logic                            S_AXI_RVALID;
    logic                            S_AXI_RREADY;

    modport master (
        output S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
               S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARVALID, S_AXI_RREADY,
        output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID,
               S_AXI_ARREADY, S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID
    );
endinterface

// File: rtl/rtclock.sv
// Free-running real-time clock (48-bit seconds, 30-bit nanoseconds) with
// PPS discipline, software time set, snapshot reads and an AXI4-Lite
// register file.
// Optional macro RTCLOCK_PPS2_CAPTURE_EN: when defined, a rising edge of
// pps2 captures sec[31:0]/nsec into PPS2_SEC_LO/PPS2_NSEC; when undefined
// pps2 is ignored and those registers read 0.
module rtclock #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 32,
    parameter logic [31:0] C_BASEADDR         = 32'h0000_0000,
    parameter int          C_CLK_TO_NS_RATIO  = 8
) (
    input  logic         clk,
    input  logic         reset,
    rtclock_if.slave     s_axi,
    output logic [47:0]  sec,
    output logic [29:0]  nsec,
    input  logic         pps,
    input  logic         pps2
);

    if (C_S_AXI_DATA_WIDTH != 32) begin : g_bad_width
        $error("rtclock supports only a 32-bit AXI-Lite data bus");
    end

    localparam logic [C_S_AXI_ADDR_WIDTH-1:0] BASE = C_S_AXI_ADDR_WIDTH'(C_BASEADDR);
    localparam logic [30:0] NS_PER_SEC = 31'd1_000_000_000;
    localparam logic [29:0] HALF_SEC   = 30'd500_000_000;
    localparam logic [30:0] RATIO      = 31'(C_CLK_TO_NS_RATIO);

    localparam logic [5:0] R_ID      = 6'd0;
    localparam logic [5:0] R_VERSION = 6'd1;
    localparam logic [5:0] R_FLIP    = 6'd2;
    localparam logic [5:0] R_CTRL    = 6'd3;
    localparam logic [5:0] R_SET_LO  = 6'd4;
    localparam logic [5:0] R_SET_HI  = 6'd5;
    localparam logic [5:0] R_SET_NS  = 6'd6;
    localparam logic [5:0] R_SNAP_LO = 6'd7;
    localparam logic [5:0] R_SNAP_HI = 6'd8;
    localparam logic [5:0] R_SNAP_NS = 6'd9;
    localparam logic [5:0] R_P2_SEC  = 6'd10;
    localparam logic [5:0] R_P2_NS   = 6'd11;

    // One clock of nanosecond advance; bit 30 is the carry into seconds.
    function automatic logic [30:0] time_step(input logic [29:0] ns);
        logic [30:0] n;
        n = {1'b0, ns} + RATIO;
        if (n >= NS_PER_SEC)
            return {1'b1, 30'(n - NS_PER_SEC)};
        return {1'b0, n[29:0]};
    endfunction

    logic [C_S_AXI_ADDR_WIDTH-1:0] wr_off, rd_off;
    logic [5:0]  wr_idx, rd_idx;
    logic        wr_en, rd_en, load_time, pps_d, pps_edge;
    logic [30:0] step;
    logic [31:0] flip_q, set_sec_lo, rd_data;
    logic [15:0] set_sec_hi, snap_sec_hi;
    logic [29:0] set_nsec, snap_nsec;
    logic        ctrl_en;
    logic [31:0] pps2_sec_rd;
    logic [29:0] pps2_nsec_rd;
    logic        unused_ok;

    assign wr_off    = s_axi.S_AXI_AWADDR - BASE;
    assign rd_off    = s_axi.S_AXI_ARADDR - BASE;
    assign wr_idx    = wr_off[7:2];
    assign rd_idx    = rd_off[7:2];
    assign wr_en     = s_axi.S_AXI_AWREADY && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID;
    assign rd_en     = s_axi.S_AXI_ARREADY && s_axi.S_AXI_ARVALID;
    assign load_time = wr_en && (wr_idx == R_CTRL) && s_axi.S_AXI_WDATA[1];
    assign pps_edge  = ctrl_en && pps && !pps_d;
    assign step      = time_step(nsec);
    assign unused_ok = ^{s_axi.S_AXI_WSTRB, wr_off[C_S_AXI_ADDR_WIDTH-1:8], wr_off[1:0],
                         rd_off[C_S_AXI_ADDR_WIDTH-1:8], rd_off[1:0]};

    assign s_axi.S_AXI_BRESP = 2'b00;
    assign s_axi.S_AXI_RRESP = 2'b00;

    // Time base: software load beats a PPS edge, which beats the normal tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            sec   <= '0;
            nsec  <= '0;
            pps_d <= 1'b0;
        end else begin
            pps_d <= pps;
            if (load_time) begin
                sec  <= {set_sec_hi, set_sec_lo};
                nsec <= set_nsec;
            end else if (pps_edge) begin
                nsec <= '0;
                if (nsec >= HALF_SEC)
                    sec <= sec + 48'd1;
            end else begin
                sec  <= sec + {47'd0, step[30]};
                nsec <= step[29:0];
            end
        end
    end

    // Write channel: accept address and data together, then hold BVALID until BREADY.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi.S_AXI_AWREADY <= 1'b0;
            s_axi.S_AXI_WREADY  <= 1'b0;
            s_axi.S_AXI_BVALID  <= 1'b0;
        end else begin
            s_axi.S_AXI_AWREADY <= 1'b0;
            s_axi.S_AXI_WREADY  <= 1'b0;
            if (!s_axi.S_AXI_AWREADY && s_axi.S_AXI_AWVALID && s_axi.S_AXI_WVALID &&
                !s_axi.S_AXI_BVALID) begin
                s_axi.S_AXI_AWREADY <= 1'b1;
                s_axi.S_AXI_WREADY  <= 1'b1;
            end
            if (wr_en)
                s_axi.S_AXI_BVALID <= 1'b1;
            else if (s_axi.S_AXI_BREADY)
                s_axi.S_AXI_BVALID <= 1'b0;
        end
    end

    // Writable registers; load_time is not stored so CTRL[1] reads back 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            flip_q     <= '0;
            ctrl_en    <= 1'b0;
            set_sec_lo <= '0;
            set_sec_hi <= '0;
            set_nsec   <= '0;
        end else if (wr_en) begin
            case (wr_idx)
                R_FLIP:   flip_q     <= s_axi.S_AXI_WDATA;
                R_CTRL:   ctrl_en    <= s_axi.S_AXI_WDATA[0];
                R_SET_LO: set_sec_lo <= s_axi.S_AXI_WDATA;
                R_SET_HI: set_sec_hi <= s_axi.S_AXI_WDATA[15:0];
                R_SET_NS: set_nsec   <= s_axi.S_AXI_WDATA[29:0];
                default:  ;
            endcase
        end
    end

    // Reading SNAP_SEC_LO freezes the rest of the timestamp for later reads.
    always_ff @(posedge clk) begin
        if (reset) begin
            snap_sec_hi <= '0;
            snap_nsec   <= '0;
        end else if (rd_en && (rd_idx == R_SNAP_LO)) begin
            snap_sec_hi <= sec[47:32];
            snap_nsec   <= nsec;
        end
    end

`ifdef RTCLOCK_PPS2_CAPTURE_EN
    logic        pps2_d;
    logic [31:0] pps2_sec_q;
    logic [29:0] pps2_nsec_q;

    // Capture the current time on each rising edge of pps2.
    always_ff @(posedge clk) begin
        if (reset) begin
            pps2_d      <= 1'b0;
            pps2_sec_q  <= '0;
            pps2_nsec_q <= '0;
        end else begin
            pps2_d <= pps2;
            if (pps2 && !pps2_d) begin
                pps2_sec_q  <= sec[31:0];
                pps2_nsec_q <= nsec;
            end
        end
    end

    assign pps2_sec_rd  = pps2_sec_q;
    assign pps2_nsec_rd = pps2_nsec_q;
`else
    logic unused_pps2;
    assign unused_pps2  = pps2;
    assign pps2_sec_rd  = '0;
    assign pps2_nsec_rd = '0;
`endif

    // Read mux; unmapped offsets return 0.
    always_comb begin
        rd_data = '0;
        case (rd_idx)
            R_ID:      rd_data = 32'h5254_4300;
            R_VERSION: rd_data = 32'h0000_0001;
            R_FLIP:    rd_data = ~flip_q;
            R_CTRL:    rd_data = {31'd0, ctrl_en};
            R_SET_LO:  rd_data = set_sec_lo;
            R_SET_HI:  rd_data = {16'd0, set_sec_hi};
            R_SET_NS:  rd_data = {2'd0, set_nsec};
            R_SNAP_LO: rd_data = sec[31:0];
            R_SNAP_HI: rd_data = {16'd0, snap_sec_hi};
            R_SNAP_NS: rd_data = {2'd0, snap_nsec};
            R_P2_SEC:  rd_data = pps2_sec_rd;
            R_P2_NS:   rd_data = {2'd0, pps2_nsec_rd};
            default:   rd_data = '0;
        endcase
    end

    // Read channel: one-cycle ARREADY pulse, data held until RREADY.
    always_ff @(posedge clk) begin
        if (reset) begin
            s_axi.S_AXI_ARREADY <= 1'b0;
            s_axi.S_AXI_RVALID  <= 1'b0;
            s_axi.S_AXI_RDATA   <= '0;
        end else begin
            s_axi.S_AXI_ARREADY <= !s_axi.S_AXI_ARREADY && s_axi.S_AXI_ARVALID &&
                                   !s_axi.S_AXI_RVALID;
            if (rd_en) begin
                s_axi.S_AXI_RVALID <= 1'b1;
                s_axi.S_AXI_RDATA  <= rd_data;
            end else if (s_axi.S_AXI_RREADY) begin
                s_axi.S_AXI_RVALID <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rtclock.sv
// Randomized self-checking bench for rtclock. Time is modelled as a single
// total-nanosecond count; registers as plain variables updated on bus events.
module tb_rtclock;
    localparam logic [31:0]     BASE  = 32'h4000_0000;
    localparam int              RATIO = 8;
    localparam longint unsigned NS    = 64'd1_000_000_000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pps = 1'b0;
    logic        pps2 = 1'b0;
    logic [47:0] sec;
    logic [29:0] nsec;
    logic        chk_on = 1'b0;

    rtclock_if axi ();

    rtclock #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(32),
        .C_BASEADDR(BASE),
        .C_CLK_TO_NS_RATIO(RATIO)
    ) dut (
        .clk(clk),
        .reset(reset),
        .s_axi(axi),
        .sec(sec),
        .nsec(nsec),
        .pps(pps),
        .pps2(pps2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model state
    longint unsigned m_tot;
    logic            m_en, m_pps_prev, m_pps2_prev;
    logic [31:0]     m_flip, m_set_lo, m_p2_sec;
    logic [15:0]     m_set_hi, m_snap_hi;
    logic [29:0]     m_set_ns, m_snap_ns, m_p2_ns;
    logic [31:0]     exp_rd[$];

    always @(posedge clk) begin : model
        longint unsigned cur_sec, cur_ns;
        logic [31:0] woff, roff, e;
        logic wr, rd;
        if (reset) begin
            m_tot = 0; m_en = 0; m_pps_prev = 0; m_pps2_prev = 0;
            m_flip = 0; m_set_lo = 0; m_set_hi = 0; m_set_ns = 0;
            m_snap_hi = 0; m_snap_ns = 0; m_p2_sec = 0; m_p2_ns = 0;
            exp_rd.delete();
        end else begin
            cur_sec = m_tot / NS;
            cur_ns  = m_tot % NS;
            wr   = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY && axi.S_AXI_WVALID;
            rd   = axi.S_AXI_ARVALID && axi.S_AXI_ARREADY;
            woff = axi.S_AXI_AWADDR - BASE;
            roff = axi.S_AXI_ARADDR - BASE;
            if (rd) begin
                case (roff)
                    32'h00: e = 32'h5254_4300;
                    32'h04: e = 32'h0000_0001;
                    32'h08: e = ~m_flip;
                    32'h0C: e = {31'd0, m_en};
                    32'h10: e = m_set_lo;
                    32'h14: e = {16'd0, m_set_hi};
                    32'h18: e = {2'd0, m_set_ns};
                    32'h1C: begin
                        e = cur_sec[31:0];
                        m_snap_hi = cur_sec[47:32];
                        m_snap_ns = cur_ns[29:0];
                    end
                    32'h20: e = {16'd0, m_snap_hi};
                    32'h24: e = {2'd0, m_snap_ns};
                    32'h28: e = m_p2_sec;
                    32'h2C: e = {2'd0, m_p2_ns};
                    default: e = 32'd0;
                endcase
                exp_rd.push_back(e);
            end
`ifdef RTCLOCK_PPS2_CAPTURE_EN
            if (pps2 && !m_pps2_prev) begin
                m_p2_sec = cur_sec[31:0];
                m_p2_ns  = cur_ns[29:0];
            end
`endif
            if (wr && woff == 32'h0C && axi.S_AXI_WDATA[1])
                m_tot = {16'd0, m_set_hi, m_set_lo} * NS + 64'(m_set_ns);
            else if (m_en && pps && !m_pps_prev)
                m_tot = ((m_tot + NS / 2) / NS) * NS;
            else
                m_tot = m_tot + RATIO;
            if (wr) begin
                case (woff)
                    32'h08: m_flip   = axi.S_AXI_WDATA;
                    32'h0C: m_en     = axi.S_AXI_WDATA[0];
                    32'h10: m_set_lo = axi.S_AXI_WDATA;
                    32'h14: m_set_hi = axi.S_AXI_WDATA[15:0];
                    32'h18: m_set_ns = axi.S_AXI_WDATA[29:0];
                    default: ;
                endcase
            end
            m_pps_prev  = pps;
            m_pps2_prev = pps2;
        end
    end

    // Continuous comparison of the running time against the model
    always @(negedge clk) begin
        if (chk_on && !reset) begin
            check("sec", 64'(sec), m_tot / NS);
            check("nsec", 64'(nsec), m_tot % NS);
        end
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic axi_write(input logic [7:0] off, input logic [31:0] data);
        int n;
        @(negedge clk);
        axi.S_AXI_AWADDR  = BASE + 32'(off);
        axi.S_AXI_AWVALID = 1'b1;
        axi.S_AXI_WDATA   = data;
        axi.S_AXI_WSTRB   = 4'($urandom);
        axi.S_AXI_WVALID  = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!axi.S_AXI_AWREADY && n < 50);
        if (!axi.S_AXI_AWREADY) begin
            check("awready_timeout", 64'(axi.S_AXI_AWREADY), 64'd1);
            axi.S_AXI_AWVALID = 1'b0;
            axi.S_AXI_WVALID  = 1'b0;
            return;
        end
        check("wready", 64'(axi.S_AXI_WREADY), 64'd1);
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        n = 0;
        while (!axi.S_AXI_BVALID && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bvalid", 64'(axi.S_AXI_BVALID), 64'd1);
        check("bresp", 64'(axi.S_AXI_BRESP), 64'd0);
        axi.S_AXI_BREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_BREADY = 1'b0;
        check("bvalid_clr", 64'(axi.S_AXI_BVALID), 64'd0);
    endtask

    task automatic axi_read(input logic [7:0] off, output logic [31:0] data);
        int n;
        logic [31:0] e;
        data = 32'd0;
        @(negedge clk);
        axi.S_AXI_ARADDR  = BASE + 32'(off);
        axi.S_AXI_ARVALID = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!axi.S_AXI_ARREADY && n < 50);
        if (!axi.S_AXI_ARREADY) begin
            check("arready_timeout", 64'(axi.S_AXI_ARREADY), 64'd1);
            axi.S_AXI_ARVALID = 1'b0;
            return;
        end
        @(negedge clk);
        axi.S_AXI_ARVALID = 1'b0;
        n = 0;
        while (!axi.S_AXI_RVALID && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rvalid", 64'(axi.S_AXI_RVALID), 64'd1);
        check("rresp", 64'(axi.S_AXI_RRESP), 64'd0);
        data = axi.S_AXI_RDATA;
        e = (exp_rd.size() > 0) ? exp_rd.pop_front() : 32'hDEAD_BEEF;
        check($sformatf("rdata@%02h", off), 64'(data), 64'(e));
        axi.S_AXI_RREADY = 1'b1;
        @(negedge clk);
        axi.S_AXI_RREADY = 1'b0;
        check("rvalid_clr", 64'(axi.S_AXI_RVALID), 64'd0);
    endtask

    task automatic pulse(input bit second, input int width);
        @(negedge clk);
        if (second) pps2 = 1'b1; else pps = 1'b1;
        repeat (width) @(negedge clk);
        pps = 1'b0;
        pps2 = 1'b0;
    endtask

    task automatic set_time(input logic [31:0] s_lo, input logic [31:0] s_hi,
                            input logic [29:0] ns, input logic en);
        axi_write(8'h10, s_lo);
        axi_write(8'h14, s_hi);
        axi_write(8'h18, {2'd0, ns});
        axi_write(8'h0C, {30'd0, 1'b1, en});
    endtask

    logic [7:0] offs[14] = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10, 8'h14, 8'h18,
                             8'h1C, 8'h20, 8'h24, 8'h28, 8'h2C, 8'h30, 8'hFC};
    int         pps_targets[4] = '{600_000_000, 300_000_000, 499_999_990, 500_000_000};

    initial begin
        logic [31:0] d, v;
        axi.S_AXI_AWADDR = '0; axi.S_AXI_AWVALID = 0; axi.S_AXI_WDATA = '0;
        axi.S_AXI_WSTRB = '0; axi.S_AXI_WVALID = 0; axi.S_AXI_BREADY = 0;
        axi.S_AXI_ARADDR = '0; axi.S_AXI_ARVALID = 0; axi.S_AXI_RREADY = 0;
        repeat (3) @(negedge clk);
        check("rst_sec", 64'(sec), 64'd0);
        check("rst_nsec", 64'(nsec), 64'd0);
        check("rst_awready", 64'(axi.S_AXI_AWREADY), 64'd0);
        check("rst_wready", 64'(axi.S_AXI_WREADY), 64'd0);
        check("rst_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        check("rst_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
        check("rst_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
        reset = 1'b0;
        chk_on = 1'b1;

        // Register map after reset, including unmapped offsets
        foreach (offs[i]) axi_read(offs[i], d);
        axi_read(8'h00, d);
        check("id_const", 64'(d), 64'h5254_4300);
        axi_read(8'h08, d);
        check("flip_reset", 64'(d), 64'hFFFF_FFFF);

        axi_write(8'h08, 32'h1234_5678);
        axi_read(8'h08, d);
        check("flip_const", 64'(d), 64'hEDCB_A987);
        repeat (4) begin
            axi_write(8'h08, $urandom);
            axi_read(8'h08, d);
        end
        axi_write(8'h30, $urandom);
        axi_write(8'h00, $urandom);
        axi_read(8'h30, d);
        axi_read(8'h00, d);

        // Time set and CTRL self-clear
        set_time(32'd5, 32'd0, 30'd100, 1'b0);
        axi_read(8'h0C, d);
        check("ctrl_selfclr", 64'(d), 64'd0);

        // Seconds rollover near the boundary, with upper seconds bits used
        repeat (3) begin
            set_time($urandom, $urandom_range(0, 1), 30'(999_999_992 - 8 * $urandom_range(0, 3)), 1'b0);
            repeat (6) @(negedge clk);
        end

        // PPS discipline enabled: directed targets then random ones
        foreach (pps_targets[i]) begin
            set_time($urandom_range(0, 1000), 32'd0, 30'(pps_targets[i]), 1'b1);
            pulse(1'b0, 1);
            repeat (3) @(negedge clk);
        end
        repeat (6) begin
            set_time($urandom, 32'd0, 30'($urandom_range(0, 999_999_000)), 1'b1);
            repeat ($urandom_range(0, 10)) @(negedge clk);
            pulse(1'b0, $urandom_range(1, 4));
            repeat ($urandom_range(1, 5)) @(negedge clk);
        end
        // PPS discipline disabled
        set_time(32'd7, 32'd0, 30'd700_000_000, 1'b0);
        pulse(1'b0, 2);
        repeat (3) @(negedge clk);

        // Snapshot holds the time of the SNAP_SEC_LO read
        set_time(32'd9, 32'd1, 30'd123_456, 1'b0);
        axi_read(8'h1C, d);
        repeat (100) @(negedge clk);
        axi_read(8'h24, d);
        axi_read(8'h20, d);
        check("snap_sec_hi", 64'(d), 64'd1);

        // Secondary pulse capture (or zeros without the feature)
        repeat (3) begin
            repeat ($urandom_range(1, 20)) @(negedge clk);
            pulse(1'b1, $urandom_range(1, 3));
            axi_read(8'h28, d);
            axi_read(8'h2C, d);
        end

        // Random mix of bus traffic and pulses
        repeat (30) begin
            case ($urandom_range(0, 5))
                0: axi_read(offs[$urandom_range(0, 13)], d);
                1: axi_write(8'h08, $urandom);
                2: axi_write(8'h10, $urandom);
                3: axi_write(8'h14, $urandom & 32'hFFFF_0001);
                4: axi_write(8'h18, $urandom_range(0, 999_999_999));
                default: begin
                    v = $urandom;
                    if (v[0]) axi_write(8'h0C, {30'd0, v[2:1]});
                    else pulse(1'b0, $urandom_range(1, 3));
                end
            endcase
        end

        // Reset in the middle of a write handshake
        @(negedge clk);
        axi.S_AXI_AWADDR = BASE + 32'h08; axi.S_AXI_WDATA = 32'hA5A5_A5A5;
        axi.S_AXI_AWVALID = 1'b1; axi.S_AXI_WVALID = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        axi.S_AXI_AWVALID = 1'b0; axi.S_AXI_WVALID = 1'b0;
        @(negedge clk);
        check("midrst_awready", 64'(axi.S_AXI_AWREADY), 64'd0);
        check("midrst_bvalid", 64'(axi.S_AXI_BVALID), 64'd0);
        check("midrst_arready", 64'(axi.S_AXI_ARREADY), 64'd0);
        check("midrst_rvalid", 64'(axi.S_AXI_RVALID), 64'd0);
        reset = 1'b0;
        axi_read(8'h08, d);
        check("flip_after_rst", 64'(d), 64'hFFFF_FFFF);
        repeat (4) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
